// File: rtl/sfu_pkg.sv
// Shared types, default widths and saturation helpers for the sfu_acc_bank slice.
package sfu_pkg;

    localparam int SFU_PSUM_BW  = 16;
    localparam int SFU_ACC_BW   = 24;
    localparam int SFU_INPUT_CH = 16;
    localparam int SFU_WIDE     = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2
    } sfu_state_t;

    typedef logic signed [SFU_WIDE-1:0] sfu_wide_t;

    // Clamp a wide signed value into the signed range of a w-bit field.
    function automatic sfu_wide_t sat_w(input sfu_wide_t x, input int w);
        sfu_wide_t hi;
        sfu_wide_t lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

    function automatic sfu_wide_t sat_acc(input sfu_wide_t x, input int acc_w);
        return sat_w(x, acc_w);
    endfunction

    function automatic sfu_wide_t sat_out(input sfu_wide_t x, input int out_w);
        return sat_w(x, out_w);
    endfunction

endpackage

// File: rtl/sfu_acc_bank_sat_relu.sv
// Combinational acc_bw -> psum_bw saturation followed by ReLU when SFU_RELU_EN is defined.
// Zero latency; purely combinational, sits on the drain read path.
module sfu_sat_relu
    import sfu_pkg::*;
#(
    parameter int acc_bw  = SFU_ACC_BW,
    parameter int psum_bw = SFU_PSUM_BW
) (
    input  logic signed [acc_bw-1:0]  acc_i,
    output logic signed [psum_bw-1:0] psum_o
);

    logic signed [psum_bw-1:0] sat_v;

    always_comb begin
        sat_v = psum_bw'(sat_out(sfu_wide_t'(acc_i), psum_bw));
`ifdef SFU_RELU_EN
        psum_o = sat_v[psum_bw-1] ? '0 : sat_v;
`else
        psum_o = sat_v;
`endif
    end

endmodule

// File: rtl/sfu_acc_bank.sv
// Saturating per-channel psum accumulator bank, drained one channel per cycle with clear-on-read.
// Accept-to-bank 1 cycle; drain shows channel k two+k edges after out_req. ReLU via SFU_RELU_EN.
module sfu_acc_bank
    import sfu_pkg::*;
#(
    parameter int psum_bw  = SFU_PSUM_BW,
    parameter int acc_bw   = SFU_ACC_BW,
    parameter int input_ch = SFU_INPUT_CH,
    parameter int ch_bw    = $clog2(input_ch)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic signed [psum_bw-1:0] psum_in,
    input  logic                      valid,
    input  logic                      enable,
    input  logic                      out_req,
    output logic signed [psum_bw-1:0] psum_out,
    output logic                      out_valid,
    output logic [ch_bw-1:0]          out_ch,
    output logic                      out_last,
    output logic                      busy,
    output logic                      drop_err
);

    localparam logic [ch_bw-1:0] LAST_CH = ch_bw'(input_ch - 1);

    sfu_state_t state_q, state_d;
    logic signed [acc_bw-1:0] bank_q [input_ch];
    logic signed [acc_bw-1:0] bank_d [input_ch];
    logic [ch_bw-1:0] in_ptr_q, in_ptr_d;
    logic [ch_bw-1:0] out_ptr_q, out_ptr_d;
    logic signed [psum_bw-1:0] psum_out_q, psum_out_d;
    logic out_valid_q, out_valid_d;
    logic [ch_bw-1:0] out_ch_q, out_ch_d;
    logic out_last_q, out_last_d;
    logic busy_q, busy_d;
    logic drop_err_q, drop_err_d;
    logic accept;
    logic signed [psum_bw-1:0] drain_val;

    sfu_sat_relu #(
        .acc_bw  (acc_bw),
        .psum_bw (psum_bw)
    ) u_sat_relu (
        .acc_i  (bank_q[out_ptr_q]),
        .psum_o (drain_val)
    );

    assign accept = valid & enable;

    always_comb begin
        state_d     = state_q;
        bank_d      = bank_q;
        in_ptr_d    = in_ptr_q;
        out_ptr_d   = out_ptr_q;
        psum_out_d  = '0;
        out_valid_d = 1'b0;
        out_ch_d    = '0;
        out_last_d  = 1'b0;
        drop_err_d  = drop_err_q;

        case (state_q)
            IDLE, ACC: begin
                // The accept is folded into the bank before a same-cycle drain starts reading.
                if (accept) begin
                    bank_d[in_ptr_q] = acc_bw'(sat_acc(sfu_wide_t'(bank_q[in_ptr_q])
                                                      + sfu_wide_t'(psum_in), acc_bw));
                    in_ptr_d = (in_ptr_q == LAST_CH) ? '0 : in_ptr_q + ch_bw'(1);
                    state_d  = ACC;
                end
                if (out_req) begin
                    state_d   = DRAIN;
                    out_ptr_d = '0;
                end
            end
            DRAIN: begin
                if (accept) begin
                    drop_err_d = 1'b1;
                end
                // One tail cycle after the last channel keeps busy high before returning to IDLE.
                if (out_last_q) begin
                    state_d   = IDLE;
                    in_ptr_d  = '0;
                    out_ptr_d = '0;
                end else begin
                    psum_out_d        = drain_val;
                    out_valid_d       = 1'b1;
                    out_ch_d          = out_ptr_q;
                    out_last_d        = (out_ptr_q == LAST_CH);
                    bank_d[out_ptr_q] = '0;
                    out_ptr_d         = (out_ptr_q == LAST_CH) ? '0 : out_ptr_q + ch_bw'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == DRAIN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            bank_q      <= '{default: '0};
            in_ptr_q    <= '0;
            out_ptr_q   <= '0;
            psum_out_q  <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            drop_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bank_q      <= bank_d;
            in_ptr_q    <= in_ptr_d;
            out_ptr_q   <= out_ptr_d;
            psum_out_q  <= psum_out_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            drop_err_q  <= drop_err_d;
        end
    end

    assign psum_out  = psum_out_q;
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign drop_err  = drop_err_q;

endmodule

// File: tb/tb_sfu_acc_bank.sv
// Bench for sfu_acc_bank (4 channels): table vectors, directed drain corner cases, random vs model.
module tb_sfu_acc_bank;

    localparam int N  = 4;
    localparam int PW = 16;
    localparam int AW = 24;
`ifdef SFU_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    typedef struct {
        string nm;
        int    ch;
        int    val;
        int    reps;
        int    exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset, valid, enable, out_req;
    logic signed [PW-1:0] psum_in, psum_out;
    logic out_valid, out_last, busy, drop_err;
    logic [1:0] out_ch;

    int     n_tests = 0;
    int     n_fail  = 0;
    longint mdl [N];
    int     mptr;
    bit     exp_drop;
    longint got [N];

    always #5 clk = ~clk;

    sfu_acc_bank #(
        .psum_bw  (PW),
        .acc_bw   (AW),
        .input_ch (N)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .psum_in   (psum_in),
        .valid     (valid),
        .enable    (enable),
        .out_req   (out_req),
        .psum_out  (psum_out),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_last  (out_last),
        .busy      (busy),
        .drop_err  (drop_err)
    );

    function automatic void check(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endfunction

    function automatic longint clamp(input longint x, input int w);
        longint hi = (longint'(1) << (w - 1)) - 1;
        longint lo = -hi - 1;
        return (x > hi) ? hi : ((x < lo) ? lo : x);
    endfunction

    function automatic longint exp_out(input longint v);
        longint s = clamp(v, PW);
        if (RELU && s < 0) s = 0;
        return s;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < N; i++) mdl[i] = 0;
        mptr = 0;
    endfunction

    // One idle/accumulate cycle; the model only takes gated accepts.
    task automatic cyc(input bit v, input bit en, input int x);
        valid   = v;
        enable  = en;
        psum_in = PW'(x);
        @(posedge clk); #1;
        if (v && en) begin
            mdl[mptr] = clamp(mdl[mptr] + longint'(x), AW);
            mptr = (mptr + 1) % N;
        end
        valid  = 1'b0;
        enable = 1'b0;
    endtask

    task automatic drain(input string nm, input int drop_at, input int rst_at,
                         input bit sim_acc, input int sim_val);
        out_req = 1'b1;
        if (sim_acc) begin
            valid = 1'b1; enable = 1'b1; psum_in = PW'(sim_val);
        end
        @(posedge clk); #1;
        if (sim_acc) begin
            mdl[mptr] = clamp(mdl[mptr] + longint'(sim_val), AW);
            mptr = (mptr + 1) % N;
        end
        out_req = 1'b0; valid = 1'b0; enable = 1'b0;
        check({nm, "_busy_start"}, busy, 1);
        check({nm, "_vld_start"}, out_valid, 0);
        for (int k = 0; k < N; k++) begin
            if (k == drop_at) begin
                valid = 1'b1; enable = 1'b1; psum_in = 16'sd99;
            end
            if (k == rst_at) reset = 1'b1;
            @(posedge clk); #1;
            valid = 1'b0; enable = 1'b0; reset = 1'b0;
            if (k == rst_at) begin
                check({nm, "_rst_psum"}, psum_out, 0);
                check({nm, "_rst_vld"}, out_valid, 0);
                check({nm, "_rst_ch"}, out_ch, 0);
                check({nm, "_rst_last"}, out_last, 0);
                check({nm, "_rst_busy"}, busy, 0);
                check({nm, "_rst_drop"}, drop_err, 0);
                model_clear();
                exp_drop = 1'b0;
                return;
            end
            if (k == drop_at) exp_drop = 1'b1;
            got[k] = longint'(psum_out);
            check($sformatf("%s_vld%0d", nm, k), out_valid, 1);
            check($sformatf("%s_ch%0d", nm, k), out_ch, k);
            check($sformatf("%s_val%0d", nm, k), psum_out, exp_out(mdl[k]));
            check($sformatf("%s_last%0d", nm, k), out_last, (k == N - 1) ? 1 : 0);
            check($sformatf("%s_busy%0d", nm, k), busy, 1);
            mdl[k] = 0;
        end
        @(posedge clk); #1;
        check({nm, "_busy_end"}, busy, 0);
        check({nm, "_vld_end"}, out_valid, 0);
        check({nm, "_psum_end"}, psum_out, 0);
        check({nm, "_last_end"}, out_last, 0);
        check({nm, "_drop_end"}, drop_err, exp_drop);
        mptr = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [6];
        tbl[0] = '{"sat_pos",  0,  30000,   3, 32767};
        tbl[1] = '{"sat_neg",  0, -30000,   3, RELU ? 0 : -32768};
        tbl[2] = '{"relu_mix", 1,     -5,   1, RELU ? 0 : -5};
        tbl[3] = '{"plain",    2,   1234,   2, 2468};
        tbl[4] = '{"acc_sat",  3,  32767, 260, 32767};
        tbl[5] = '{"neg_sm",   3,   -100,   2, RELU ? 0 : -200};

        reset = 1'b1; valid = 1'b0; enable = 1'b0; out_req = 1'b0; psum_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_psum", psum_out, 0);
        check("rst_vld", out_valid, 0);
        check("rst_ch", out_ch, 0);
        check("rst_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_drop", drop_err, 0);
        reset = 1'b0;
        model_clear();
        exp_drop = 1'b0;

        // Basic accumulate: 1..4 twice gives 2,4,6,8, then an empty bank.
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < N; c++) cyc(1'b1, 1'b1, c + 1);
        drain("basic", -1, -1, 1'b0, 0);
        for (int c = 0; c < N; c++) check($sformatf("basic_const%0d", c), got[c], 2 * (c + 1));
        drain("basic_zero", -1, -1, 1'b0, 0);
        for (int c = 0; c < N; c++) check($sformatf("basic_zero_const%0d", c), got[c], 0);

        foreach (tbl[i]) begin
            for (int r = 0; r < tbl[i].reps; r++)
                for (int c = 0; c < N; c++) cyc(1'b1, 1'b1, (c == tbl[i].ch) ? tbl[i].val : 0);
            drain(tbl[i].nm, -1, -1, 1'b0, 0);
            check({tbl[i].nm, "_tbl"}, got[tbl[i].ch], tbl[i].exp);
        end

        // Accept during drain is dropped and flagged.
        for (int c = 0; c < N; c++) cyc(1'b1, 1'b1, 10 + c);
        drain("drop", 1, -1, 1'b0, 0);
        check("drop_flag", drop_err, 1);
        drain("drop_after", -1, -1, 1'b0, 0);
        for (int c = 0; c < N; c++) check($sformatf("drop_after_const%0d", c), got[c], 0);

        // Partial pass then a fresh accept must land on channel 0.
        cyc(1'b1, 1'b1, 21);
        cyc(1'b1, 1'b1, 22);
        drain("partial", -1, -1, 1'b0, 0);
        cyc(1'b1, 1'b1, 11);
        drain("restart", -1, -1, 1'b0, 0);
        check("restart_ch0", got[0], 11);

        // Same-cycle accept and out_req, then gated accepts.
        drain("simul", -1, -1, 1'b1, 7);
        check("simul_ch0", got[0], 7);
        for (int c = 0; c < N; c++) cyc(1'b1, 1'b0, 50);
        drain("gated", -1, -1, 1'b0, 0);
        for (int c = 0; c < N; c++) check($sformatf("gated_const%0d", c), got[c], 0);

        // Reset during the third drain cycle.
        for (int c = 0; c < N; c++) cyc(1'b1, 1'b1, 300 + c);
        drain("rstmid", -1, 2, 1'b0, 0);
        drain("rstmid_after", -1, -1, 1'b0, 0);
        for (int c = 0; c < N; c++) check($sformatf("rstmid_const%0d", c), got[c], 0);

        // Random accumulation rounds against the model.
        for (int r = 0; r < 6; r++) begin
            int len;
            len = int'($urandom_range(10, 80));
            for (int i = 0; i < len; i++) begin
                int sel, x;
                sel = int'($urandom_range(0, 3));
                x = (sel == 0) ? 32767 : ((sel == 1) ? -32768 : int'($urandom_range(0, 65535)) - 32768);
                cyc(($urandom_range(0, 7) != 0), ($urandom_range(0, 5) != 0), x);
            end
            drain($sformatf("rnd%0d", r), -1, -1, 1'b0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
